// File: rtl/sw_debounce_ctr.sv
// Slide-switch input conditioner.
// Each raw switch bit is brought into clk_in through a two-flop synchroniser.
// It is then debounced by its own stability counter. The block produces a
// clean level per bit and registered one-cycle rise/fall/any-change strobes.
// Downstream divider and LED-pattern logic can use these strobes to restart
// cleanly on a rate change.
module sw_debounce_ctr #(
  parameter int WIDTH        = 4,
  parameter int DEBOUNCE_CYC = 100000,
  parameter int CNT_W        = 17
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  // Last count value before a new level is accepted.
  // With DEBOUNCE_CYC == 1 this is 0, so the first mismatching cycle is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_nxt  [WIDTH];
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  // Two-flop synchroniser; only sync2 is allowed to reach the debounce logic.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Per-bit stability count: any cycle that agrees with the accepted level
  // clears the count, so only an uninterrupted run of DEBOUNCE_CYC
  // mismatching cycles moves sw_stable.
  always_comb begin
    stable_nxt = sw_stable;
    rise_nxt   = '0;
    fall_nxt   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync2[i] == sw_stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        cnt_nxt[i]    = '0;
        stable_nxt[i] = sync2[i];
        rise_nxt[i]   = sync2[i];
        fall_nxt[i]   = ~sync2[i];
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end
    end
  end

  // Registered debounce state and strobes.
  // The strobes appear in the same cycle as the new sw_stable value.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      sw_stable  <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      sw_stable  <= stable_nxt;
      sw_rise    <= rise_nxt;
      sw_fall    <= fall_nxt;
      sw_changed <= |(rise_nxt | fall_nxt);
    end
  end

endmodule
